// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default timing and frame shape.
// Intended for reuse by both the transmitter and a future receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 434;
  localparam int UART_FRAME_BITS           = 10;
  localparam int UART_DATA_BITS            = 8;

  function automatic int uartFrameCycles(input int clksPerBit);
    return UART_FRAME_BITS * clksPerBit;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO buffering bytes for the transmitter.
// A push while full is ignored even if a pop happens on the same edge.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pushOk;
  logic             popOk;

  assign full_o  = (count_q == DEPTH[AW:0]);
  assign empty_o = (count_q == '0);
  assign pushOk  = push_i & ~full_o;
  assign popOk   = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (pushOk) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (popOk) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({pushOk, popOk})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered bytes shifted out LSB-first on an idle-high line.
// The STOP state pops the next byte directly into START so queued frames have no gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wen,
  input  logic [7:0] wdata,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          overflow_q;

  logic          fifoPop;
  logic [7:0]    fifoDout;
  logic          fifoFull;
  logic          fifoEmpty;
  logic          bitEnd;

  uart_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wen),
    .pop_i   (fifoPop),
    .din_i   (wdata),
    .dout_o  (fifoDout),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign bitEnd = (bcnt_q == BCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          state_d = START;
        end
      end
      START: begin
        if (bitEnd) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bitEnd && (bidx_q == 3'd7)) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bitEnd) begin
          state_d = fifoEmpty ? IDLE : START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: tx is computed one cycle ahead so the pin comes straight from a flop.
  always_comb begin
    tx_d    = tx_q;
    bcnt_d  = bitEnd ? '0 : bcnt_q + BW'(1);
    bidx_d  = bidx_q;
    shift_d = shift_q;
    fifoPop = 1'b0;
    case (state_q)
      IDLE: begin
        bcnt_d = '0;
        tx_d   = 1'b1;
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          shift_d = fifoDout;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bitEnd) begin
          tx_d   = shift_q[0];
          bidx_d = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          shift_d = {1'b0, shift_q[7:1]};
          bidx_d  = bidx_q + 3'd1;
          tx_d    = (bidx_q == 3'd7) ? 1'b1 : shift_q[1];
        end
      end
      STOP: begin
        if (bitEnd && !fifoEmpty) begin
          fifoPop = 1'b1;
          shift_d = fifoDout;
          tx_d    = 1'b0;
        end
      end
      default: begin
        tx_d   = 1'b1;
        bcnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (wen && fifoFull) begin
      overflow_q <= 1'b1;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE) | ~fifoEmpty;
  assign full     = fifoFull;
  assign overflow = overflow_q;

endmodule
